trace_player: RTL

TRACE_PLAYER -- requirements
Module: trace_player

---
 rtl/trace_player.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/trace_player.sv
// -----------------------------------------------------------------------------
// trace_player
//   Plays back a small stored pattern of lane values, one step per clock.
//   The pattern memory is written through the cfg_* port while the player is
//   idle or done; playback runs steps 0..len once, or repeatedly when loop_en
//   is set at start, and can be paused or stopped at any time.
//
// Parameters
//   DEPTH    number of pattern steps (power of two, >= 2)
//   LANES    number of output lanes (lane 0 = A, 1 = B, 2 = C, 3 = D)
//
// Ports
//   clock    sole clock, rising edge
//   resetn   asynchronous active-low reset
//   cfg_we   pattern write strobe
//   cfg_addr pattern step index to write
//   cfg_data lane values for that step
//   start    begin playback (ignored while playing)
//   stop     abort playback and return to idle (highest priority)
//   pause    hold the current step while high
//   loop_en  restart at step 0 after the last step
//   len      index of the last step to play
//   lanes    registered lane outputs
//   step     index of the step currently driven
//   busy     high in RUN or PAUSE
//   done     high in DONE
//   cfg_err  one-cycle pulse after a write attempted during playback
//   loops    completed passes since the last start, saturating at 255
// -----------------------------------------------------------------------------
module trace_player #(
    parameter  int DEPTH = 32,
    parameter  int LANES = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [LANES-1:0] cfg_data,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             loop_en,
    input  logic [AW-1:0]    len,
    output logic [LANES-1:0] lanes,
    output logic [AW-1:0]    step,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [7:0]       loops
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [AW-1:0]    len_q;
    logic             loop_q;
    logic [LANES-1:0] mem [DEPTH];

    logic             stopped;
    logic             write_ok;
    logic [AW-1:0]    step_inc;
    logic [7:0]       loops_inc;
    logic [LANES-1:0] first_lanes;

    // The pattern is only writable while nothing is being played.
    assign stopped   = (state == IDLE) || (state == DONE);
    assign write_ok  = cfg_we && stopped;
    assign step_inc  = step + AW'(1);
    assign loops_inc = (loops == 8'hFF) ? loops : loops + 8'd1;

    // Write-first bypass: a write to step 0 in the same cycle as start must
    // be the first value played, before the memory itself has updated.
    assign first_lanes = (write_ok && (cfg_addr == '0)) ? cfg_data : mem[0];

    assign busy = (state == RUN) || (state == PAUSE);
    assign done = (state == DONE);

    // Pattern memory.
    // NOTE: every entry is cleared by reset so a start before any write
    // plays a known all-zero pattern; this keeps the store as flops, not RAM.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_ok) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    // Playback state machine with registered outputs.
    // NOTE: all state here uses non-blocking assignments so every branch
    // reads the pre-edge values of step, loops and state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            lanes   <= '0;
            step    <= '0;
            loops   <= '0;
            cfg_err <= 1'b0;
            len_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !stopped;

            if (stop) begin
                // Abort is not a completed pass, so loops is left alone.
                state <= IDLE;
                lanes <= '0;
                step  <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state  <= RUN;
                            step   <= '0;
                            lanes  <= first_lanes;
                            loops  <= '0;
                            len_q  <= len;
                            loop_q <= loop_en;
                        end
                    end

                    RUN: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else if (step < len_q) begin
                            step  <= step_inc;
                            lanes <= mem[step_inc];
                        end else if (loop_q) begin
                            step  <= '0;
                            lanes <= mem[0];
                            loops <= loops_inc;
                        end else begin
                            state <= DONE;
                            step  <= '0;
                            lanes <= '0;
                            loops <= loops_inc;
                        end
                    end

                    PAUSE: begin
                        // Returning to RUN holds the step one more cycle.
                        if (!pause) begin
                            state <= RUN;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
